fir_seq: RTL and testbench

FIR_SEQ -- requirements
Module: fir_seq

---
 rtl/fir_seq_pkg.sv | 36 +++
 rtl/fir_seq_if.sv | 13 +
 rtl/fir_seq_mac.sv | 60 ++++++
 rtl/fir_seq.sv | 149 ++++++++++++++
 tb/tb_fir_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_seq_pkg.sv
// Shared definitions for the sequential FIR filter: default widths,
// controller state encoding and the output saturation helper.
package fir_seq_pkg;

    localparam int DEF_DW    = 24;
    localparam int DEF_CW    = 18;
    localparam int DEF_ACCW  = 48;
    localparam int DEF_NTAPS = 16;
    localparam int DEF_SHIFT = 17;

    // Working width of the saturation helper; wide enough for any ACCW+1 input.
    localparam int SAT_IW = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // Clamp a signed value to the range of a dw-bit signed number (dw <= 64).
    function automatic logic signed [63:0] saturate(input logic signed [SAT_IW-1:0] v,
                                                    input int dw);
        logic signed [SAT_IW-1:0] hi;
        logic signed [SAT_IW-1:0] lo;
        hi = (128'sd1 <<< (dw - 1)) - 128'sd1;
        lo = -(128'sd1 <<< (dw - 1));
        if (v > hi)
            return hi[63:0];
        else if (v < lo)
            return lo[63:0];
        else
            return v[63:0];
    endfunction

endpackage

// File: rtl/fir_seq_if.sv
// Valid/ready sample stream used for both the input and output side of fir_seq.
interface fir_seq_if
    import fir_seq_pkg::*;
#(
    parameter int DW = DEF_DW
);
    logic signed [DW-1:0] tdata;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/fir_seq_mac.sv
// Three-stage signed multiply-accumulate: operand register, product register,
// accumulator. sload restarts the sum with the current product; ce marks a
// valid operand pair and travels down the pipe alongside the data.
module fir_seq_mac #(
    parameter int DW   = 24,
    parameter int CW   = 18,
    parameter int ACCW = 48
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [DW-1:0]   a,
    input  logic signed [CW-1:0]   b,
    input  logic                   sload,
    input  logic                   ce,
    output logic signed [ACCW-1:0] accum_o
);
    logic signed [DW-1:0]      a_p0;
    logic signed [CW-1:0]      b_p0;
    logic                      vld_p0, sload_p0;
    logic signed [DW+CW-1:0]   prod_p1;
    logic                      vld_p1, sload_p1;
    logic signed [ACCW-1:0]    acc_p2;
    logic signed [ACCW-1:0]    prod_ext;

    assign prod_ext = ACCW'(prod_p1);
    assign accum_o  = acc_p2;

    // Control: valid and start-of-sum flags follow the data through the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0   <= 1'b0;
            sload_p0 <= 1'b0;
            vld_p1   <= 1'b0;
            sload_p1 <= 1'b0;
        end else begin
            vld_p0   <= ce;
            sload_p0 <= sload;
            vld_p1   <= vld_p0;
            sload_p1 <= sload_p0;
        end
    end

    // Stage p0 -> p1: operand capture, then signed product.
    always_ff @(posedge clk) begin
        if (ce) begin
            a_p0 <= a;
            b_p0 <= b;
        end
        if (vld_p0)
            prod_p1 <= a_p0 * b_p0;
    end

    // Stage p2: accumulator, restarted on the first tap of each sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_p2 <= '0;
        else if (vld_p1)
            acc_p2 <= sload_p1 ? prod_ext : acc_p2 + prod_ext;
    end
endmodule

// File: rtl/fir_seq.sv
// Sequential (one MAC) FIR filter with a circular delay line and writable
// coefficients. One sample is accepted, NTAPS products are summed, the sum is
// shifted, saturated and presented on the output stream until taken.
// Optional build macro FIR_SEQ_ROUND_EN: round half up before the shift
// instead of truncating; latency is the same either way.
module fir_seq
    import fir_seq_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int CW    = DEF_CW,
    parameter  int ACCW  = DEF_ACCW,
    parameter  int NTAPS = DEF_NTAPS,
    parameter  int SHIFT = DEF_SHIFT,
    localparam int AW    = $clog2(NTAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fir_seq_if.slave             s_axis,
    fir_seq_if.master            m_axis,
    input  logic                 coef_wr,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    output logic                 coef_busy
);
    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);

    state_t                 state, state_nxt;
    logic [AW-1:0]          wptr, wptr_inc, tap_cnt, rd_idx;
    logic [1:0]             drain_cnt;
    logic                   s_ready, accept, out_vld;
    logic signed [DW-1:0]   out_data, shaped;
    logic signed [DW-1:0]   dline [NTAPS];
    logic signed [CW-1:0]   coef  [NTAPS];
    logic signed [ACCW-1:0] acc;
    logic signed [ACCW:0]   acc_sh;
    logic                   mac_ce, mac_sload;

    // Optional rounding bias; one extra bit keeps the addition from wrapping.
    function automatic logic signed [ACCW:0] round_acc(input logic signed [ACCW-1:0] v);
        logic signed [ACCW:0] r;
        r = (ACCW+1)'(v);
`ifdef FIR_SEQ_ROUND_EN
        if (SHIFT > 0)
            r = r + ((ACCW+1)'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0));
`endif
        return r;
    endfunction

    assign accept        = (state == IDLE) && s_ready && s_axis.tvalid;
    assign coef_busy     = (state != IDLE);
    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = out_vld;
    assign m_axis.tdata  = out_data;
    assign wptr_inc      = (wptr == LAST_TAP) ? '0 : wptr + 1'b1;
    assign mac_ce        = (state == RUN);
    assign mac_sload     = (state == RUN) && (tap_cnt == '0);

    // Next-state: accept -> NTAPS issue cycles -> 3 drain cycles -> hold output.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (tap_cnt == LAST_TAP) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_nxt = OUT;
            OUT:     if (out_vld && m_axis.tready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, tap/drain counters and the registered input ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tap_cnt   <= '0;
            drain_cnt <= '0;
            s_ready   <= 1'b0;
        end else begin
            state     <= state_nxt;
            tap_cnt   <= (state == RUN && state_nxt == RUN) ? tap_cnt + 1'b1 : '0;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            s_ready   <= (state_nxt == IDLE);
        end
    end

    // Delay line: the newest sample lands one slot past the previous one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                dline[i] <= '0;
            wptr <= '0;
        end else if (accept) begin
            dline[wptr_inc] <= s_axis.tdata;
            wptr            <= wptr_inc;
        end
    end

    // Coefficient bank, writable only while idle; out-of-range addresses are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAPS; i++)
                coef[i] <= '0;
        end else if (state == IDLE && coef_wr && int'(coef_addr) < NTAPS) begin
            coef[coef_addr] <= coef_data;
        end
    end

    // Tap i reads the sample i positions older than the newest one.
    always_comb begin
        if (wptr >= tap_cnt)
            rd_idx = wptr - tap_cnt;
        else
            rd_idx = AW'(int'(wptr) + NTAPS - int'(tap_cnt));
    end

    fir_seq_mac #(
        .DW   (DW),
        .CW   (CW),
        .ACCW (ACCW)
    ) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (dline[rd_idx]),
        .b       (coef[tap_cnt]),
        .sload   (mac_sload),
        .ce      (mac_ce),
        .accum_o (acc)
    );

    // Output shaping: optional rounding, arithmetic shift, saturation to DW.
    always_comb begin
        acc_sh = round_acc(acc) >>> SHIFT;
        shaped = DW'(saturate(SAT_IW'(acc_sh), DW));
    end

    // Output register: loaded on the first OUT cycle, held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (state == OUT) begin
            if (!out_vld) begin
                out_vld  <= 1'b1;
                out_data <= shaped;
            end else if (m_axis.tready) begin
                out_vld  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_seq.sv
// Bench for fir_seq: three instances (SHIFT = 0, 17, 1) share clock and reset;
// each output is compared with a direct-form convolution model per instance.
`timescale 1ns/1ps
module tb_fir_seq;
    import fir_seq_pkg::*;

    localparam int DW   = 24;
    localparam int CW   = 18;
    localparam int ACCW = 48;
    localparam int NT   = 16;
    localparam int AW   = 4;
    localparam int NI   = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic signed [DW-1:0] s_tdata   [NI];
    logic                 s_tvalid  [NI];
    logic                 m_tready  [NI];
    logic                 coef_wr   [NI];
    logic [AW-1:0]        coef_addr [NI];
    logic signed [CW-1:0] coef_data [NI];
    wire                  s_tready  [NI];
    wire                  m_tvalid  [NI];
    wire signed [DW-1:0]  m_tdata   [NI];
    wire                  coef_busy [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int SH = (k == 0) ? 0 : ((k == 1) ? 17 : 1);
        fir_seq_if #(.DW(DW)) s_if ();
        fir_seq_if #(.DW(DW)) m_if ();
        assign s_if.tdata  = s_tdata[k];
        assign s_if.tvalid = s_tvalid[k];
        assign s_tready[k] = s_if.tready;
        assign m_tdata[k]  = m_if.tdata;
        assign m_tvalid[k] = m_if.tvalid;
        assign m_if.tready = m_tready[k];
        fir_seq #(.DW(DW), .CW(CW), .ACCW(ACCW), .NTAPS(NT), .SHIFT(SH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .s_axis    (s_if),
            .m_axis    (m_if),
            .coef_wr   (coef_wr[k]),
            .coef_addr (coef_addr[k]),
            .coef_data (coef_data[k]),
            .coef_busy (coef_busy[k])
        );
    end

    int n_chk = 0;
    int n_err = 0;

    longint mc [NI][NT];   // model coefficients
    longint mh [NI][NT];   // model history, index 0 = newest sample

    task automatic check_val(input string tag, input logic signed [63:0] got,
                             input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int shift_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 17 : 1);
    endfunction

    task automatic reset_model();
        for (int k = 0; k < NI; k++)
            for (int i = 0; i < NT; i++) begin
                mc[k][i] = 0;
                mh[k][i] = 0;
            end
    endtask

    task automatic model_push(input int k, input longint x);
        for (int i = NT - 1; i > 0; i--)
            mh[k][i] = mh[k][i-1];
        mh[k][0] = x;
    endtask

    function automatic longint model_out(input int k);
        longint acc = 0;
        longint hi = (longint'(1) <<< (DW - 1)) - 1;
        longint lo = -(longint'(1) <<< (DW - 1));
        int sh = shift_of(k);
        for (int i = 0; i < NT; i++)
            acc += mc[k][i] * mh[k][i];
`ifdef FIR_SEQ_ROUND_EN
        if (sh > 0) acc += longint'(1) <<< (sh - 1);
`endif
        acc = acc >>> sh;
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
        return acc;
    endfunction

    task automatic chk_reset(input int k);
        check_val("rst_s_tready", s_tready[k], 0);
        check_val("rst_m_tvalid", m_tvalid[k], 0);
        check_val("rst_m_tdata", m_tdata[k], 0);
        check_val("rst_coef_busy", coef_busy[k], 0);
    endtask

    task automatic wait_sready(input int k);
        int n = 0;
        while (s_tready[k] !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check_val("s_tready_wait", s_tready[k], 1);
    endtask

    task automatic write_coef(input int k, input int a, input longint d);
        coef_wr[k]   = 1'b1;
        coef_addr[k] = AW'(a);
        coef_data[k] = CW'(d);
        @(posedge clk); #1;
        coef_wr[k] = 1'b0;
        if (a < NT) mc[k][a] = d;
    endtask

    // One sample through instance k: optional output stall, a dropped coefficient
    // write during RUN, or a reset pulse rst_at cycles after the accept.
    task automatic send(input int k, input longint x, input int stall, input bit busy_wr,
                        input int rst_at, output longint y);
        int n;
        longint expv;
        logic signed [DW-1:0] held;
        y = 0;
        wait_sready(k);
        m_tready[k] = (stall == 0);
        s_tdata[k]  = DW'(x);
        s_tvalid[k] = 1'b1;
        if (coef_wr[k]) mc[k][int'(coef_addr[k])] = longint'(coef_data[k]);
        @(posedge clk); #1;
        s_tvalid[k] = 1'b0;
        coef_wr[k]  = 1'b0;
        model_push(k, x);
        expv = model_out(k);
        check_val("busy_after_accept", coef_busy[k], 1);
        n = 0;
        while (m_tvalid[k] !== 1'b1 && n < 60) begin
            if (busy_wr && n == 2) begin
                check_val("busy_during_run", coef_busy[k], 1);
                coef_wr[k]   = 1'b1;
                coef_addr[k] = '0;
                coef_data[k] = CW'(5);
            end
            if (rst_at > 0 && n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset(k);
                #1;
                rst_n = 1'b1;
                reset_model();
            end
            @(posedge clk); #1;
            coef_wr[k] = 1'b0;
            if (rst_at > 0 && n == rst_at)
                check_val("sready_after_rst", s_tready[k], 1);
            n++;
        end
        if (rst_at > 0) begin
            check_val("no_out_after_rst", m_tvalid[k], 0);
            m_tready[k] = 1'b1;
            return;
        end
        check_val("latency", n, NT + 4);
        check_val("data", m_tdata[k], expv);
        y    = m_tdata[k];
        held = m_tdata[k];
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check_val("hold_tvalid", m_tvalid[k], 1);
            check_val("hold_tdata", m_tdata[k], held);
            check_val("hold_s_tready", s_tready[k], 0);
        end
        m_tready[k] = 1'b1;
        @(posedge clk); #1;
        check_val("released", m_tvalid[k], 0);
        check_val("sready_back", s_tready[k], 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, limit 500000 ns");
        $fatal(1);
    end

    initial begin
        longint y;
        logic signed [DW-1:0] rx;
        logic signed [CW-1:0] rc;
        for (int k = 0; k < NI; k++) begin
            s_tdata[k] = '0; s_tvalid[k] = 1'b0; m_tready[k] = 1'b1;
            coef_wr[k] = 1'b0; coef_addr[k] = '0; coef_data[k] = '0;
        end
        reset_model();

        // Reset state and first edge after release
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) chk_reset(k);
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) check_val("sready_first_edge", s_tready[k], 1);

        // Impulse, SHIFT=0, c[i]=i+1
        for (int i = 0; i < NT; i++) write_coef(0, i, i + 1);
        for (int j = 0; j <= NT; j++) begin
            send(0, (j == 0) ? 1 : 0, 0, 1'b0, 0, y);
            check_val("impulse", y, (j < NT) ? j + 1 : 0);
        end

        // Saturation, SHIFT=17
        for (int i = 0; i < NT; i++) write_coef(1, i, 131071);
        for (int j = 0; j < NT; j++) send(1, 8388607, 0, 1'b0, 0, y);
        check_val("sat_pos", y, 8388607);
        for (int j = 0; j < NT; j++) send(1, -8388608, 0, 1'b0, 0, y);
        check_val("sat_neg", y, -8388608);

        // Rounding, SHIFT=1, c[0]=1
        write_coef(2, 0, 1);
        send(2, 3, 0, 1'b0, 0, y);
`ifdef FIR_SEQ_ROUND_EN
        check_val("round_pos", y, 2);
`else
        check_val("round_pos", y, 1);
`endif
        send(2, -3, 0, 1'b0, 0, y);
`ifdef FIR_SEQ_ROUND_EN
        check_val("round_neg", y, -1);
`else
        check_val("round_neg", y, -2);
`endif

        // Backpressure: 10 stalled cycles in OUT
        send(1, 1000000, 10, 1'b0, 0, y);

        // Coefficient write during RUN is dropped
        send(0, 7, 0, 1'b1, 0, y);
        send(0, 3, 0, 1'b0, 0, y);

        // Randomized coefficients, samples, stalls and same-cycle coefficient writes
        for (int i = 0; i < NT; i++) begin
            rc = CW'($urandom);
            write_coef(1, i, longint'(rc));
        end
        for (int j = 0; j < 20; j++) begin
            if (j % 4 == 3) begin
                rc = CW'($urandom);
                coef_wr[1]   = 1'b1;
                coef_addr[1] = AW'($urandom_range(0, NT - 1));
                coef_data[1] = rc;
            end
            rx = DW'($urandom);
            send(1, longint'(rx), $urandom_range(0, 3), 1'b0, 0, y);
        end

        // Reset pulse in RUN cycle 5, then a clean impulse
        send(0, 1, 0, 1'b0, 5, y);
        for (int i = 0; i < NT; i++) write_coef(0, i, i + 1);
        for (int j = 0; j <= NT; j++) begin
            send(0, (j == 0) ? 1 : 0, 0, 1'b0, 0, y);
            check_val("impulse_after_rst", y, (j < NT) ? j + 1 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
